// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus bundle.
//   master : result sources side (drives src_* and flush_all, observes the writeback ports)
//   slave  : the arbiter (accepts src_*, drives src_ready and all wb_* outputs)
// Signals:
//   flush_all          discard all pending results
//   src_valid/ready    per-source result handshake
//   src_class          2 bits per source: 00 scalar, 01 FP, 10 vector, 11 illegal
//   src_rd             5 bits per source destination register
//   src_data           VLEN bits per source result data
//   wb_<class>_*       per-class register-file write port (valid is a 1-cycle strobe)
//   err_invalid_class  sticky flag set when a class-11 result is accepted
interface wb_arbiter_if #(
  parameter int NUM_SRC = 4,
  parameter int XLEN    = 32,
  parameter int VLEN    = 128
);
  logic                    flush_all;
  logic [NUM_SRC-1:0]      src_valid;
  logic [NUM_SRC-1:0]      src_ready;
  logic [2*NUM_SRC-1:0]    src_class;
  logic [5*NUM_SRC-1:0]    src_rd;
  logic [VLEN*NUM_SRC-1:0] src_data;
  logic                    wb_scalar_valid;
  logic [4:0]              wb_scalar_rd;
  logic [XLEN-1:0]         wb_scalar_data;
  logic                    wb_fp_valid;
  logic [4:0]              wb_fp_rd;
  logic [XLEN-1:0]         wb_fp_data;
  logic                    wb_vec_valid;
  logic [4:0]              wb_vec_rd;
  logic [VLEN-1:0]         wb_vec_data;
  logic                    err_invalid_class;

  modport master (
    output flush_all, src_valid, src_class, src_rd, src_data,
    input  src_ready,
    input  wb_scalar_valid, wb_scalar_rd, wb_scalar_data,
    input  wb_fp_valid, wb_fp_rd, wb_fp_data,
    input  wb_vec_valid, wb_vec_rd, wb_vec_data,
    input  err_invalid_class
  );

  modport slave (
    input  flush_all, src_valid, src_class, src_rd, src_data,
    output src_ready,
    output wb_scalar_valid, wb_scalar_rd, wb_scalar_data,
    output wb_fp_valid, wb_fp_rd, wb_fp_data,
    output wb_vec_valid, wb_vec_rd, wb_vec_data,
    output err_invalid_class
  );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter of the compute unit.
// Collects results from NUM_SRC execution sources into one holding register per
// source, then round-robin arbitrates per register class (scalar, FP, vector) so
// that each class register file sees at most one write per cycle.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  wb_arbiter_if.slave (source handshakes, flush, writeback ports, error flag)
//
// Handshake: a source result transfers on a rising edge where src_valid[i] and
// src_ready[i] are both 1; src_ready[i] does not depend on src_valid[i]. A source
// whose holding register is being drained this cycle may refill it in the same
// cycle, giving one result per cycle per source. Writeback ports have no
// backpressure: wb_*_valid is a one-cycle strobe, rd/data hold between strobes.
module wb_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int XLEN    = 32,
  parameter int VLEN    = 128
) (
  input logic       clk,
  input logic       rst,
  wb_arbiter_if.slave bus
);
  localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  // Holding registers
  logic [NUM_SRC-1:0] full;
  logic [1:0]         h_class [NUM_SRC];
  logic [4:0]         h_rd    [NUM_SRC];
  logic [VLEN-1:0]    h_data  [NUM_SRC];

  // Round-robin pointers (last granted source), index 0 scalar, 1 FP, 2 vector
  logic [PW-1:0] ptr [3];

  // Unpacked source inputs
  logic [1:0]      in_class [NUM_SRC];
  logic [4:0]      in_rd    [NUM_SRC];
  logic [VLEN-1:0] in_data  [NUM_SRC];

  logic [2:0]         found;
  logic [PW-1:0]      gidx [3];
  logic [NUM_SRC-1:0] grant;
  logic [NUM_SRC-1:0] accept;

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      in_class[i] = bus.src_class[2*i +: 2];
      in_rd[i]    = bus.src_rd[5*i +: 5];
      in_data[i]  = bus.src_data[VLEN*i +: VLEN];
    end
  end

  // Per-class round robin: scan from ptr+1 upward (wrapping), first full holder
  // of the matching class wins. Flush suppresses every grant.
  always_comb begin
    logic [PW-1:0] idx_v;
    idx_v = '0;
    found = '0;
    grant = '0;
    for (int c = 0; c < 3; c++) gidx[c] = '0;
    for (int c = 0; c < 3; c++) begin
      for (int k = 1; k <= NUM_SRC; k++) begin
        idx_v = PW'((int'(ptr[c]) + k) % NUM_SRC);
        if (!found[c] && full[idx_v] && (h_class[idx_v] == 2'(c))) begin
          found[c] = 1'b1;
          gidx[c]  = idx_v;
        end
      end
    end
    if (bus.flush_all) found = '0;
    for (int c = 0; c < 3; c++) begin
      if (found[c]) grant[gidx[c]] = 1'b1;
    end
  end

  assign bus.src_ready = {NUM_SRC{~bus.flush_all}} & (~full | grant);
  assign accept        = bus.src_valid & bus.src_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      full                  <= '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        h_class[i] <= '0;
        h_rd[i]    <= '0;
        h_data[i]  <= '0;
      end
      for (int c = 0; c < 3; c++) ptr[c] <= '0;
      bus.wb_scalar_valid   <= 1'b0;
      bus.wb_scalar_rd      <= '0;
      bus.wb_scalar_data    <= '0;
      bus.wb_fp_valid       <= 1'b0;
      bus.wb_fp_rd          <= '0;
      bus.wb_fp_data        <= '0;
      bus.wb_vec_valid      <= 1'b0;
      bus.wb_vec_rd         <= '0;
      bus.wb_vec_data       <= '0;
      bus.err_invalid_class <= 1'b0;
    end else if (bus.flush_all) begin
      // Pending results are dropped; pointers and last rd/data are kept.
      full             <= '0;
      bus.wb_scalar_valid <= 1'b0;
      bus.wb_fp_valid     <= 1'b0;
      bus.wb_vec_valid    <= 1'b0;
    end else begin
      bus.wb_scalar_valid <= found[0];
      if (found[0]) begin
        bus.wb_scalar_rd   <= h_rd[gidx[0]];
        bus.wb_scalar_data <= h_data[gidx[0]][XLEN-1:0];
        ptr[0]             <= gidx[0];
      end
      bus.wb_fp_valid <= found[1];
      if (found[1]) begin
        bus.wb_fp_rd   <= h_rd[gidx[1]];
        bus.wb_fp_data <= h_data[gidx[1]][XLEN-1:0];
        ptr[1]         <= gidx[1];
      end
      bus.wb_vec_valid <= found[2];
      if (found[2]) begin
        bus.wb_vec_rd   <= h_rd[gidx[2]];
        bus.wb_vec_data <= h_data[gidx[2]];
        ptr[2]          <= gidx[2];
      end
      for (int i = 0; i < NUM_SRC; i++) begin
        if (accept[i]) begin
          // Writes to x0 and illegal-class results are consumed here and never
          // reach a register file.
          full[i]    <= (in_class[i] != 2'b11) &&
                        !((in_class[i] == 2'b00) && (in_rd[i] == 5'd0));
          h_class[i] <= in_class[i];
          h_rd[i]    <= in_rd[i];
          h_data[i]  <= in_data[i];
          if (in_class[i] == 2'b11) bus.err_invalid_class <= 1'b1;
        end else if (grant[i]) begin
          full[i] <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;
  localparam int NUM_SRC = 4;
  localparam int XLEN    = 32;
  localparam int VLEN    = 128;
  localparam int EW      = 32 + 5 + VLEN;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] cyc = '0;
  always @(posedge clk) cyc <= cyc + 1;

  wb_arbiter_if #(.NUM_SRC(NUM_SRC), .XLEN(XLEN), .VLEN(VLEN)) bus ();

  wb_arbiter #(.NUM_SRC(NUM_SRC), .XLEN(XLEN), .VLEN(VLEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard: per class (0 scalar, 1 FP, 2 vector) {cycle, rd, data}
  logic [EW-1:0] exp_q [3][$];

  task automatic check(input string nm, input logic [VLEN-1:0] act, input logic [VLEN-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [VLEN-1:0] lo(input logic [VLEN-1:0] d);
    logic [VLEN-1:0] r;
    r = '0;
    r[XLEN-1:0] = d[XLEN-1:0];
    return r;
  endfunction

  task automatic exp_push(input int c, input logic [31:0] at, input logic [4:0] rd,
                          input logic [VLEN-1:0] d);
    exp_q[c].push_back({at, rd, d});
  endtask

  // Driver tasks
  task automatic drive_src(input int i, input logic [1:0] cls, input logic [4:0] rd,
                           input logic [VLEN-1:0] d);
    bus.src_valid[i]           = 1'b1;
    bus.src_class[2*i +: 2]    = cls;
    bus.src_rd[5*i +: 5]       = rd;
    bus.src_data[VLEN*i +: VLEN] = d;
  endtask

  // Check src_ready mid-cycle, then complete the cycle and drop all valids.
  task automatic step(input logic [NUM_SRC-1:0] exp_ready, input logic [NUM_SRC-1:0] mask,
                      input string nm);
    @(negedge clk);
    check(nm, VLEN'(bus.src_ready & mask), VLEN'(exp_ready & mask));
    @(posedge clk);
    #1;
    bus.src_valid = '0;
  endtask

  task automatic wait_idle(input string nm);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 60 && !done; k++) begin
      @(negedge clk);
      if (exp_q[0].size() == 0 && exp_q[1].size() == 0 && exp_q[2].size() == 0) done = 1'b1;
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s: scoreboard not drained within 60 cycles, expected empty", nm);
    end
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares every writeback strobe against the class queue, and
  // reports expected strobes whose cycle passed without being seen.
  task automatic mon_class(input int c, input logic v, input logic [4:0] rd,
                           input logic [VLEN-1:0] d, input string nm);
    logic [EW-1:0] e;
    logic [31:0]   at;
    while (exp_q[c].size() > 0) begin
      e  = exp_q[c][0];
      at = e[EW-1 -: 32];
      if (at >= cyc) break;
      void'(exp_q[c].pop_front());
      n_checks++;
      n_fail++;
      $display("FAIL %s_missing: got no strobe at cycle %0d, expected rd=%0d data=0x%0h",
               nm, at, e[VLEN +: 5], e[VLEN-1:0]);
    end
    if (v) begin
      n_checks++;
      if (exp_q[c].size() == 0) begin
        n_fail++;
        $display("FAIL %s_unexpected: got strobe rd=%0d data=0x%0h at cycle %0d, expected none",
                 nm, rd, d, cyc);
      end else begin
        e = exp_q[c].pop_front();
        if (e !== {cyc, rd, d}) begin
          n_fail++;
          $display("FAIL %s_pulse: got cycle=%0d rd=%0d data=0x%0h, expected cycle=%0d rd=%0d data=0x%0h",
                   nm, cyc, rd, d, e[EW-1 -: 32], e[VLEN +: 5], e[VLEN-1:0]);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon_class(0, bus.wb_scalar_valid, bus.wb_scalar_rd, lo(VLEN'(bus.wb_scalar_data)), "scalar");
      mon_class(1, bus.wb_fp_valid, bus.wb_fp_rd, lo(VLEN'(bus.wb_fp_data)), "fp");
      mon_class(2, bus.wb_vec_valid, bus.wb_vec_rd, bus.wb_vec_data, "vec");
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

  logic [VLEN-1:0] d;
  logic [31:0]     n;
  localparam logic [VLEN-1:0] UPPER = {96'hA5A5_A5A5_5A5A_5A5A_C3C3_C3C3, 32'h0};

  initial begin
    bus.flush_all = 1'b0;
    bus.src_valid = '0;
    bus.src_class = '0;
    bus.src_rd    = '0;
    bus.src_data  = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valids", VLEN'({bus.wb_scalar_valid, bus.wb_fp_valid, bus.wb_vec_valid}), '0);
    check("rst_scalar_rd", VLEN'(bus.wb_scalar_rd), '0);
    check("rst_fp_data", VLEN'(bus.wb_fp_data), '0);
    check("rst_vec_data", bus.wb_vec_data, '0);
    check("rst_err", VLEN'(bus.err_invalid_class), '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", VLEN'(bus.src_ready), VLEN'(4'b1111));
    @(posedge clk);
    #1;

    // 1: single uncontended scalar, strobe exactly two cycles later
    n = cyc;
    drive_src(0, 2'b00, 5'd5, UPPER | 128'hDEAD_BEEF);
    exp_push(0, n + 2, 5'd5, 128'hDEAD_BEEF);
    step(4'b0001, 4'b0001, "t1_ready");
    wait_idle("t1_drain");

    // 2a: scalar pointer now at src0, so the burst starts at src1
    n = cyc;
    for (int i = 0; i < 4; i++) drive_src(i, 2'b00, 5'(i + 1), UPPER | 128'(32'h1000_0000 + i));
    exp_push(0, n + 2, 5'd2, 128'h1000_0001);
    exp_push(0, n + 3, 5'd3, 128'h1000_0002);
    exp_push(0, n + 4, 5'd4, 128'h1000_0003);
    exp_push(0, n + 5, 5'd1, 128'h1000_0000);
    step(4'b1111, 4'b1111, "t2a_ready");
    wait_idle("t2a_drain");

    // Move the scalar pointer to src3
    n = cyc;
    drive_src(3, 2'b00, 5'd9, 128'h0000_0099);
    exp_push(0, n + 2, 5'd9, 128'h0000_0099);
    step(4'b1000, 4'b1000, "t2p_ready");
    wait_idle("t2p_drain");

    // 2b/2c: two identical bursts, granted src0..src3 in order
    for (int b = 0; b < 2; b++) begin
      n = cyc;
      for (int i = 0; i < 4; i++) drive_src(i, 2'b00, 5'(i + 1), UPPER | 128'(32'h2000_0000 + i));
      for (int i = 0; i < 4; i++) exp_push(0, n + 2 + i, 5'(i + 1), 128'(32'h2000_0000 + i));
      step(4'b1111, 4'b1111, "t2b_ready");
      wait_idle("t2b_drain");
    end

    // 3: one write per class in the same cycle
    n = cyc;
    drive_src(0, 2'b00, 5'd10, UPPER | 128'h1111_2222);
    drive_src(1, 2'b01, 5'd11, UPPER | 128'h3F80_0000);
    d = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    drive_src(2, 2'b10, 5'd12, d);
    exp_push(0, n + 2, 5'd10, 128'h1111_2222);
    exp_push(1, n + 2, 5'd11, 128'h3F80_0000);
    exp_push(2, n + 2, 5'd12, d);
    step(4'b0111, 4'b0111, "t3_ready");
    wait_idle("t3_drain");

    // 4: two results held, flush before they can be granted
    drive_src(0, 2'b00, 5'd20, 128'h20);
    drive_src(1, 2'b00, 5'd21, 128'h21);
    step(4'b0011, 4'b0011, "t4_fill_ready");
    bus.flush_all = 1'b1;
    drive_src(2, 2'b00, 5'd22, 128'h22);
    step(4'b0000, 4'b1111, "t4_flush_ready");
    bus.flush_all = 1'b0;
    @(negedge clk);
    check("t4_after_ready", VLEN'(bus.src_ready), VLEN'(4'b1111));
    check("t4_after_valids", VLEN'({bus.wb_scalar_valid, bus.wb_fp_valid, bus.wb_vec_valid}), '0);
    repeat (6) @(negedge clk);
    @(posedge clk);
    #1;

    // 5: x0 write dropped, illegal class dropped and flagged
    drive_src(0, 2'b00, 5'd0, 128'hBAD0);
    step(4'b0001, 4'b0001, "t5_x0_ready");
    repeat (4) @(negedge clk);
    check("t5_err_before", VLEN'(bus.err_invalid_class), '0);
    @(posedge clk);
    #1;
    drive_src(1, 2'b11, 5'd7, 128'hBAD7);
    step(4'b0010, 4'b0010, "t5_cls3_ready");
    @(negedge clk);
    check("t5_err_rise", VLEN'(bus.err_invalid_class), 128'd1);
    repeat (5) @(negedge clk);
    check("t5_err_sticky", VLEN'(bus.err_invalid_class), 128'd1);
    @(posedge clk);
    #1;

    // 6: src1 streams eight FP results back to back
    for (int i = 0; i < 8; i++) begin
      n = cyc;
      drive_src(1, 2'b01, 5'(i + 1), UPPER | 128'(32'hF0F0_0000 + i));
      exp_push(1, n + 2, 5'(i + 1), 128'(32'hF0F0_0000 + i));
      step(4'b0010, 4'b0010, "t6_ready");
    end
    wait_idle("t6_drain");

    // Reset clears the sticky error and the writeback registers
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst2_err", VLEN'(bus.err_invalid_class), '0);
    check("rst2_fp_rd", VLEN'(bus.wb_fp_rd), '0);
    check("rst2_fp_data", VLEN'(bus.wb_fp_data), '0);
    check("end_queues", VLEN'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size()), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
